bus_arbiter_rr: RTL and testbench

- Parametrised N-requester bus arbiter; next generation of the 4:2 priority-encoder front end.
- Selects one requester per arbitration round in fixed-priority or round-robin mode, then holds the grant until the owner releases or a hold timeout fires.
- Registered one-hot grant, encoded index and valid.
- Sits between bus masters' request lines and the shared-bus mux select.

---
 rtl/bus_arb_pkg.sv | 15 +
 rtl/arb_prio_enc.sv | 25 ++
 rtl/bus_arbiter_rr.sv | 165 ++++++++++++++++
 tb/tb_bus_arbiter_rr.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// Shared definitions for the round-robin / fixed-priority bus arbiter.
//   state_t       : arbitration FSM encoding (IDLE = 0, BUSY = 1)
//   DEF_N         : default number of requesters
//   DEF_MAX_HOLD  : default maximum consecutive BUSY cycles per grant
package bus_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int unsigned DEF_N        = 4;
  localparam int unsigned DEF_MAX_HOLD = 16;

endpackage

// File: rtl/arb_prio_enc.sv
// Generic N:log2(N) priority encoder, lowest set bit wins.
// Generalisation of the original 4:2 encoder.
//   vec   : input request vector
//   idx   : index of the lowest set bit of vec (0 when vec is zero)
//   valid : high when any bit of vec is set
module arb_prio_enc #(
  parameter int unsigned N    = 4,
  parameter int unsigned IDXW = $clog2(N)
) (
  input  logic [N-1:0]    vec,
  output logic [IDXW-1:0] idx,
  output logic            valid
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    for (int unsigned i = N; i > 0; i--) begin
      if (vec[i-1]) idx = IDXW'(i - 1);
    end
  end

  assign valid = |vec;

endmodule

// File: rtl/bus_arbiter_rr.sv
// N-requester bus arbiter with fixed-priority or round-robin selection.
// A grant is held until the owner drops its request or the hold limit
// expires; every grant is followed by at least one idle cycle.
//   clk         : system clock, rising edge
//   rst         : asynchronous active-high reset
//   req         : level-sensitive request vector
//   grant       : registered one-hot grant (zero when idle)
//   grant_idx   : registered index of the granted requester (0 when idle)
//   grant_valid : registered, high while a grant is active
//   timeout     : one-cycle pulse when a grant is forcibly revoked
module bus_arbiter_rr
  import bus_arb_pkg::*;
#(
  parameter int unsigned N        = DEF_N,
  parameter int unsigned IDXW     = $clog2(N),
  parameter int unsigned RR_MODE  = 1,
  parameter int unsigned MAX_HOLD = DEF_MAX_HOLD,
  parameter int unsigned CNTW     = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    grant,
  output logic [IDXW-1:0] grant_idx,
  output logic            grant_valid,
  output logic            timeout
);

  localparam logic [CNTW-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNTW'(MAX_HOLD - 1);
  localparam logic [IDXW-1:0] IDX_RST   = IDXW'(N - 1);

  state_t          state, state_nxt;
  logic [CNTW-1:0] hold_cnt, hold_cnt_nxt;
  logic [IDXW-1:0] last_idx, last_idx_nxt;
  logic [IDXW-1:0] mask_idx, mask_idx_nxt;
  logic            mask_idx_valid, mask_idx_valid_nxt;
  logic [N-1:0]    grant_nxt;
  logic [IDXW-1:0] grant_idx_nxt;
  logic            grant_valid_nxt;
  logic            timeout_nxt;

  logic [N-1:0]    elig;
  logic [IDXW-1:0] win_idx;
  logic            win_valid;

  // A requester that just timed out sits out exactly one arbitration round.
  always_comb begin
    elig = req;
    if (mask_idx_valid) elig[mask_idx] = 1'b0;
  end

  if (RR_MODE != 0) begin : g_rr
    logic [N-1:0]    elig_hi;
    logic [IDXW-1:0] hi_idx, lo_idx;
    logic            hi_valid, lo_valid;

    // Requests strictly above the previous winner get first pick; if none,
    // the search wraps to the full vector starting from index 0.
    always_comb begin
      elig_hi = '0;
      for (int unsigned i = 0; i < N; i++) begin
        elig_hi[i] = elig[i] && (IDXW'(i) > last_idx);
      end
    end

    arb_prio_enc #(.N(N), .IDXW(IDXW)) u_enc_hi (
      .vec   (elig_hi),
      .idx   (hi_idx),
      .valid (hi_valid)
    );

    arb_prio_enc #(.N(N), .IDXW(IDXW)) u_enc_all (
      .vec   (elig),
      .idx   (lo_idx),
      .valid (lo_valid)
    );

    assign win_idx   = hi_valid ? hi_idx : lo_idx;
    assign win_valid = lo_valid;
  end else begin : g_fixed
    arb_prio_enc #(.N(N), .IDXW(IDXW)) u_enc (
      .vec   (elig),
      .idx   (win_idx),
      .valid (win_valid)
    );
  end

  always_comb begin
    state_nxt          = state;
    hold_cnt_nxt       = hold_cnt;
    last_idx_nxt       = last_idx;
    mask_idx_nxt       = mask_idx;
    mask_idx_valid_nxt = mask_idx_valid;
    grant_nxt          = grant;
    grant_idx_nxt      = grant_idx;
    grant_valid_nxt    = grant_valid;
    timeout_nxt        = 1'b0;

    case (state)
      IDLE: begin
        mask_idx_valid_nxt = 1'b0;
        grant_nxt          = '0;
        grant_idx_nxt      = '0;
        grant_valid_nxt    = 1'b0;
        if (win_valid) begin
          grant_nxt[win_idx] = 1'b1;
          grant_idx_nxt      = win_idx;
          grant_valid_nxt    = 1'b1;
          hold_cnt_nxt       = '0;
          last_idx_nxt       = win_idx;
          state_nxt          = BUSY;
        end
      end

      BUSY: begin
        // Release has priority over timeout on the same cycle.
        if (!req[grant_idx]) begin
          grant_nxt       = '0;
          grant_idx_nxt   = '0;
          grant_valid_nxt = 1'b0;
          hold_cnt_nxt    = '0;
          state_nxt       = IDLE;
        end else if ((MAX_HOLD != 0) && (hold_cnt == HOLD_LAST)) begin
          grant_nxt          = '0;
          grant_idx_nxt      = '0;
          grant_valid_nxt    = 1'b0;
          hold_cnt_nxt       = '0;
          timeout_nxt        = 1'b1;
          mask_idx_nxt       = grant_idx;
          mask_idx_valid_nxt = 1'b1;
          state_nxt          = IDLE;
        end else if (hold_cnt != '1) begin
          hold_cnt_nxt = hold_cnt + CNTW'(1);
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      hold_cnt       <= '0;
      last_idx       <= IDX_RST;
      mask_idx       <= '0;
      mask_idx_valid <= 1'b0;
      grant          <= '0;
      grant_idx      <= '0;
      grant_valid    <= 1'b0;
      timeout        <= 1'b0;
    end else begin
      state          <= state_nxt;
      hold_cnt       <= hold_cnt_nxt;
      last_idx       <= last_idx_nxt;
      mask_idx       <= mask_idx_nxt;
      mask_idx_valid <= mask_idx_valid_nxt;
      grant          <= grant_nxt;
      grant_idx      <= grant_idx_nxt;
      grant_valid    <= grant_valid_nxt;
      timeout        <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
module tb_bus_arbiter_rr;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req_rr = '0;
  logic [3:0] req_fp = '0;

  logic [3:0] gnt_rr, gnt_fp;
  logic [1:0] idx_rr, idx_fp;
  logic       vld_rr, vld_fp;
  logic       to_rr, to_fp;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit         rr;
    string      tag;
    logic [3:0] g;
    logic [1:0] i;
    logic       t;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  bus_arbiter_rr #(.N(4), .IDXW(2), .RR_MODE(1), .MAX_HOLD(4), .CNTW(8)) dut_rr (
    .clk         (clk),
    .rst         (rst),
    .req         (req_rr),
    .grant       (gnt_rr),
    .grant_idx   (idx_rr),
    .grant_valid (vld_rr),
    .timeout     (to_rr)
  );

  bus_arbiter_rr #(.N(4), .IDXW(2), .RR_MODE(0), .MAX_HOLD(4), .CNTW(8)) dut_fp (
    .clk         (clk),
    .rst         (rst),
    .req         (req_fp),
    .grant       (gnt_fp),
    .grant_idx   (idx_fp),
    .grant_valid (vld_fp),
    .timeout     (to_fp)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Drive one request pattern, queue the output expected after the next edge,
  // then pop and compare #1 after that edge.
  task automatic step(input bit rr, input string tag, input logic [3:0] r,
                      input logic [3:0] g, input logic [1:0] i, input logic t);
    exp_t e;
    if (rr) req_rr = r; else req_fp = r;
    sb.push_back('{rr, tag, g, i, t});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (e.rr) begin
      check_eq({e.tag, ".grant"}, 32'(gnt_rr), 32'(e.g));
      check_eq({e.tag, ".idx"},   32'(idx_rr), 32'(e.i));
      check_eq({e.tag, ".valid"}, 32'(vld_rr), 32'(|e.g));
      check_eq({e.tag, ".to"},    32'(to_rr),  32'(e.t));
    end else begin
      check_eq({e.tag, ".grant"}, 32'(gnt_fp), 32'(e.g));
      check_eq({e.tag, ".idx"},   32'(idx_fp), 32'(e.i));
      check_eq({e.tag, ".valid"}, 32'(vld_fp), 32'(|e.g));
      check_eq({e.tag, ".to"},    32'(to_fp),  32'(e.t));
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, ".rr_grant"}, 32'(gnt_rr), 32'h0);
    check_eq({tag, ".rr_idx"},   32'(idx_rr), 32'h0);
    check_eq({tag, ".rr_valid"}, 32'(vld_rr), 32'h0);
    check_eq({tag, ".rr_to"},    32'(to_rr),  32'h0);
    check_eq({tag, ".fp_grant"}, 32'(gnt_fp), 32'h0);
    check_eq({tag, ".fp_valid"}, 32'(vld_fp), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish by 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    rst = 1'b0;

    // No requests: nothing granted
    for (int k = 0; k < 5; k++) step(1, "idle", 4'b0000, 4'b0000, 2'd0, 1'b0);

    // Fixed priority: lowest index first, release, one gap, then idx 3
    step(0, "fp_g1a", 4'b1010, 4'b0010, 2'd1, 1'b0);
    step(0, "fp_g1b", 4'b1010, 4'b0010, 2'd1, 1'b0);
    step(0, "fp_gap", 4'b1000, 4'b0000, 2'd0, 1'b0);
    step(0, "fp_g3",  4'b1000, 4'b1000, 2'd3, 1'b0);
    step(0, "fp_rel", 4'b0000, 4'b0000, 2'd0, 1'b0);

    // Round robin rotation 0,1,2,3,0 with a drop after each first grant
    for (int k = 0; k < 5; k++) begin
      logic [3:0] oh;
      oh = 4'b0001 << (k % 4);
      step(1, "rr_grant", 4'b1111, oh, 2'(k % 4), 1'b0);
      step(1, "rr_drop", 4'b1111 & ~oh, 4'b0000, 2'd0, 1'b0);
    end
    step(1, "rr_quiet", 4'b0000, 4'b0000, 2'd0, 1'b0);

    // Single requester held: 4 grant cycles, timeout, masked round, regrant
    for (int k = 0; k < 4; k++) step(1, "hold1", 4'b0001, 4'b0001, 2'd0, 1'b0);
    step(1, "hold1_to",   4'b0001, 4'b0000, 2'd0, 1'b1);
    step(1, "hold1_mask", 4'b0001, 4'b0000, 2'd0, 1'b0);
    step(1, "hold1_regr", 4'b0001, 4'b0001, 2'd0, 1'b0);
    step(1, "hold1_rel",  4'b0000, 4'b0000, 2'd0, 1'b0);

    // Reset so the RR pointer restarts at N-1
    rst = 1'b1;
    #1;
    check_idle("reset2");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Two requesters held: timeouts alternate ownership 0 -> 1 -> 0
    for (int k = 0; k < 4; k++) step(1, "two_g0", 4'b0011, 4'b0001, 2'd0, 1'b0);
    step(1, "two_to0", 4'b0011, 4'b0000, 2'd0, 1'b1);
    for (int k = 0; k < 4; k++) step(1, "two_g1", 4'b0011, 4'b0010, 2'd1, 1'b0);
    step(1, "two_to1", 4'b0011, 4'b0000, 2'd0, 1'b1);
    step(1, "two_g0b", 4'b0011, 4'b0001, 2'd0, 1'b0);
    step(1, "two_rel", 4'b0000, 4'b0000, 2'd0, 1'b0);
    step(1, "two_idle", 4'b0000, 4'b0000, 2'd0, 1'b0);

    // Async reset mid-BUSY, then RR restarts from index 0 upward
    step(1, "mid_g2a", 4'b0100, 4'b0100, 2'd2, 1'b0);
    step(1, "mid_g2b", 4'b0100, 4'b0100, 2'd2, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_idle("async_rst");
    req_rr = 4'b1100;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1, "post_rst", 4'b1100, 4'b0100, 2'd2, 1'b0);
    step(1, "post_rel", 4'b0000, 4'b0000, 2'd0, 1'b0);

    check_eq("sb_empty", 32'(sb.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
